// File: rtl/fir_pkg.sv
// Shared constants for the FIR engine sequencer: engine register
// addresses, default run sizes and the sequencer state encoding.
package fir_pkg;

  localparam logic [31:0] FIR_X_ADDR = 32'h3820_0000;
  localparam logic [31:0] FIR_Y_ADDR = 32'h3820_0010;

  localparam int TAPE_NUM_DEF = 11;
  localparam int DATA_NUM_DEF = 11;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_TAP_GET  = 4'd1,
    ST_TAP_WAIT = 4'd2,
    ST_TAP_ACK  = 4'd3,
    ST_SMP_GET  = 4'd4,
    ST_SMP_WAIT = 4'd5,
    ST_SMP_ACK  = 4'd6,
    ST_RES_WAIT = 4'd7,
    ST_RES_RD   = 4'd8,
    ST_RES_PUSH = 4'd9,
    ST_ERR      = 4'd10
  } state_t;

  // States that wait on the engine and are therefore watched.
  function automatic logic is_wd_state(input state_t s);
    return s inside {ST_TAP_WAIT, ST_TAP_ACK, ST_SMP_WAIT,
                     ST_SMP_ACK, ST_RES_WAIT, ST_RES_RD};
  endfunction

endpackage

// File: rtl/fir_wb_master.sv
// Single-transaction Wishbone master (pulse write / held read) + watchdog.
// Ports: i_wr/i_rd commands, i_wdata, i_wd_en/i_adv watchdog control,
// o_timeout, fir_* Wishbone signals (all bus outputs registered).
module fir_wb_master
  import fir_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1023,
  parameter int CNT_W       = 10
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_wr,
  input  logic        i_rd,
  input  logic [31:0] i_wdata,
  input  logic        i_wd_en,
  input  logic        i_adv,
  input  logic        fir_ack_i,
  output logic        o_timeout,
  output logic        fir_stb_o,
  output logic        fir_cyc_o,
  output logic        fir_we_o,
  output logic [31:0] fir_adr_o,
  output logic [31:0] fir_dat_o
);

  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] r_wd;

  // An event that moves the FSM this cycle beats the timeout.
  assign o_timeout = i_wd_en && !i_adv && (r_wd == WD_LAST);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wd <= '0;
    end else if (!i_wd_en || i_adv) begin
      r_wd <= '0;
    end else begin
      r_wd <= r_wd + 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      fir_stb_o <= 1'b0;
      fir_cyc_o <= 1'b0;
      fir_we_o  <= 1'b0;
      fir_adr_o <= '0;
      fir_dat_o <= '0;
    end else if (o_timeout) begin
      fir_stb_o <= 1'b0;
      fir_cyc_o <= 1'b0;
      fir_we_o  <= 1'b0;
    end else if (i_wr) begin
      fir_stb_o <= 1'b1;
      fir_cyc_o <= 1'b1;
      fir_we_o  <= 1'b1;
      fir_adr_o <= FIR_X_ADDR;
      fir_dat_o <= i_wdata;
    end else if (i_rd) begin
      fir_stb_o <= 1'b1;
      fir_cyc_o <= 1'b1;
      fir_we_o  <= 1'b0;
      fir_adr_o <= FIR_Y_ADDR;
    end else if (fir_stb_o && (fir_we_o || fir_ack_i)) begin
      // Writes last one cycle; reads drop on ack.
      fir_stb_o <= 1'b0;
      fir_cyc_o <= 1'b0;
      fir_we_o  <= 1'b0;
    end
  end

endmodule

// File: rtl/fir_seq_ctrl.sv
// Sequencer: loads taps, feeds samples, reads results over Wishbone.
// Ports: start/busy/error control, s_* input stream, m_* result stream,
// fir_* Wishbone master + engine ready/done.
module fir_seq_ctrl
  import fir_pkg::*;
#(
  parameter int TAPE_NUM    = TAPE_NUM_DEF,
  parameter int DATA_NUM    = DATA_NUM_DEF,
  parameter int TIMEOUT_CYC = 1023,
  parameter int CNT_W       = 10
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        start,
  output logic        busy,
  output logic        error,
  input  logic        s_valid,
  input  logic [31:0] s_data,
  output logic        s_ready,
  output logic        m_valid,
  output logic [31:0] m_data,
  input  logic        m_ready,
  output logic        fir_stb_o,
  output logic        fir_cyc_o,
  output logic        fir_we_o,
  output logic [3:0]  fir_sel_o,
  output logic [31:0] fir_adr_o,
  output logic [31:0] fir_dat_o,
  input  logic        fir_ack_i,
  input  logic [31:0] fir_dat_i,
  input  logic        fir_ready_i,
  input  logic        fir_done_i
);

  localparam int TW = $clog2(TAPE_NUM + 1);
  localparam int DW = $clog2(DATA_NUM + 1);
  localparam logic [TW-1:0] TAP_LAST = TW'(TAPE_NUM - 1);
  localparam logic [DW-1:0] SMP_LAST = DW'(DATA_NUM - 1);

  state_t        r_state;
  logic [TW-1:0] r_tap_cnt;
  logic [DW-1:0] r_smp_cnt;
  logic [31:0]   r_word;

  logic w_adv;
  logic w_wr;
  logic w_rd;
  logic w_timeout;

  assign fir_sel_o = 4'hF;

  // Event that advances each engine-facing wait state.
  always_comb begin
    w_adv = 1'b0;
    unique case (r_state)
      ST_TAP_WAIT, ST_SMP_WAIT: w_adv = fir_ready_i;
      ST_TAP_ACK, ST_SMP_ACK,
      ST_RES_RD:                w_adv = fir_ack_i;
      ST_RES_WAIT:              w_adv = fir_done_i;
      default:                  w_adv = 1'b0;
    endcase
  end

  assign w_wr = w_adv &&
    (r_state == ST_TAP_WAIT || r_state == ST_SMP_WAIT);
  assign w_rd = w_adv && (r_state == ST_RES_WAIT);

  fir_wb_master #(
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .CNT_W      (CNT_W)
  ) u_wbm (
    .i_clk    (wb_clk_i),
    .i_rst    (wb_rst_i),
    .i_wr     (w_wr),
    .i_rd     (w_rd),
    .i_wdata  (r_word),
    .i_wd_en  (is_wd_state(r_state)),
    .i_adv    (w_adv),
    .fir_ack_i(fir_ack_i),
    .o_timeout(w_timeout),
    .fir_stb_o(fir_stb_o),
    .fir_cyc_o(fir_cyc_o),
    .fir_we_o (fir_we_o),
    .fir_adr_o(fir_adr_o),
    .fir_dat_o(fir_dat_o)
  );

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state   <= ST_IDLE;
      r_tap_cnt <= '0;
      r_smp_cnt <= '0;
      r_word    <= '0;
      busy      <= 1'b0;
      error     <= 1'b0;
      s_ready   <= 1'b0;
      m_valid   <= 1'b0;
      m_data    <= '0;
    end else if (w_timeout) begin
      r_state <= ST_ERR;
      busy    <= 1'b0;
      error   <= 1'b1;
      s_ready <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE, ST_ERR: begin
          if (start) begin
            r_tap_cnt <= '0;
            r_smp_cnt <= '0;
            error     <= 1'b0;
            busy      <= 1'b1;
            s_ready   <= 1'b1;
            r_state   <= ST_TAP_GET;
          end
        end
        ST_TAP_GET: begin
          if (s_valid) begin
            r_word  <= s_data;
            s_ready <= 1'b0;
            r_state <= ST_TAP_WAIT;
          end
        end
        ST_TAP_WAIT: if (w_adv) r_state <= ST_TAP_ACK;
        ST_TAP_ACK: begin
          if (w_adv) begin
            r_tap_cnt <= r_tap_cnt + 1'b1;
            s_ready   <= 1'b1;
            r_state   <= (r_tap_cnt == TAP_LAST) ?
                         ST_SMP_GET : ST_TAP_GET;
          end
        end
        ST_SMP_GET: begin
          if (s_valid) begin
            r_word  <= s_data;
            s_ready <= 1'b0;
            r_state <= ST_SMP_WAIT;
          end
        end
        ST_SMP_WAIT: if (w_adv) r_state <= ST_SMP_ACK;
        ST_SMP_ACK:  if (w_adv) r_state <= ST_RES_WAIT;
        ST_RES_WAIT: if (w_adv) r_state <= ST_RES_RD;
        ST_RES_RD: begin
          if (w_adv) begin
            m_data  <= fir_dat_i;
            m_valid <= 1'b1;
            r_state <= ST_RES_PUSH;
          end
        end
        ST_RES_PUSH: begin
          if (m_ready) begin
            m_valid   <= 1'b0;
            r_smp_cnt <= r_smp_cnt + 1'b1;
            if (r_smp_cnt == SMP_LAST) begin
              busy    <= 1'b0;
              r_state <= ST_IDLE;
            end else begin
              s_ready <= 1'b1;
              r_state <= ST_SMP_GET;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
